// File: rtl/hdmi_read_ctrl_if.sv
// Burst request port between the HDMI read sequencer and the DDR2 read master.
// Request is held stable by the master side until the slave acknowledges it.
interface hdmi_read_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_len,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_len,
        output mem_ack
    );
endinterface

// File: rtl/hdmi_read_ctrl.sv
// HDMI scan-out read sequencer: turns hdmi_core strobes into DDR2 burst requests.
// Optional DOUBLE_BUFFER_EN adds a swappable alternate frame buffer base.
module hdmi_read_ctrl #(
    parameter int ADDR_W          = 32,
    parameter int CHUNK_BYTES     = 128,
    parameter int CHUNKS_PER_LINE = 40,
    parameter int MAX_PENDING     = 4,
    parameter int LEN_W           = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic              read_go,
    input  logic              read_next_line,
    input  logic              read_next_chunk,
    input  logic              read_done,
`ifdef DOUBLE_BUFFER_EN
    input  logic [ADDR_W-1:0] fb_base_alt,
    input  logic              fb_swap,
    output logic              fb_front,
`endif
    hdmi_read_ctrl_if.master  mem,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overflow
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int CW = $clog2(CHUNKS_PER_LINE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_LINE_DRAIN,
        S_FRAME_DRAIN
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_pending;
    logic [CW-1:0]     r_chunk_idx;
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] r_chunk_addr;
    logic [ADDR_W-1:0] r_stride;
    logic              r_mem_req;
    logic              r_go_pend;
    logic              r_frame_done;
    logic              r_err;

    logic              w_ack;
    logic              w_accept;
    logic              w_full;
    logic              w_take;
    logic              w_drop;
    logic              w_drained;
    logic              w_start;
    logic              w_line_adv;
    logic [PW-1:0]     w_pend_nxt;
    logic [CW-1:0]     w_idx_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_base;

`ifdef DOUBLE_BUFFER_EN
    logic r_front;
    logic r_swap_pend;
    logic w_front_nxt;

    // Base selection uses the buffer that will be front after a pending swap
    always_comb begin
        w_front_nxt = r_front ^ r_swap_pend;
        w_base      = w_front_nxt ? fb_base_alt : fb_base;
    end

    // Swap requests only take effect at a frame start
    always_ff @(posedge clock) begin
        if (reset) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
        end else if (w_start) begin
            r_front     <= w_front_nxt;
            r_swap_pend <= fb_swap;
        end else if (fb_swap) begin
            r_swap_pend <= 1'b1;
        end
    end

    assign fb_front = r_front;
`else
    // Single buffer: the frame always starts at fb_base
    always_comb w_base = fb_base;
`endif

    // Chunk admission, pending count and next burst address
    always_comb begin
        w_ack      = r_mem_req & mem.mem_ack;
        w_accept   = (r_state == S_ACTIVE) || (r_state == S_LINE_DRAIN);
        w_full     = (r_pending == PW'(MAX_PENDING)) ||
                     ((32'(r_chunk_idx) + 32'(r_pending)) == 32'(CHUNKS_PER_LINE));
        w_take     = read_next_chunk & w_accept & ~w_full;
        w_drop     = read_next_chunk & w_accept & w_full;
        w_drained  = (r_pending == '0) & ~r_mem_req;
        w_start    = (r_state == S_IDLE) & (read_go | r_go_pend);
        w_line_adv = (r_state == S_LINE_DRAIN) & ~read_done & w_drained;
        w_pend_nxt = r_pending;
        if (w_take & ~w_ack)
            w_pend_nxt = r_pending + PW'(1);
        else if (~w_take & w_ack)
            w_pend_nxt = r_pending - PW'(1);
        w_addr_nxt = r_chunk_addr;
        w_idx_nxt  = r_chunk_idx;
        if (w_start) begin
            w_addr_nxt = w_base;
            w_idx_nxt  = '0;
        end else if (w_line_adv) begin
            w_addr_nxt = r_line_addr + r_stride;
            w_idx_nxt  = '0;
        end else if (w_ack) begin
            w_addr_nxt = r_chunk_addr + ADDR_W'(CHUNK_BYTES);
            w_idx_nxt  = r_chunk_idx + CW'(1);
        end
    end

    // Frame sequencing FSM with registered request and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_chunk_idx  <= '0;
            r_line_addr  <= '0;
            r_chunk_addr <= '0;
            r_stride     <= '0;
            r_mem_req    <= 1'b0;
            r_go_pend    <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pending    <= w_pend_nxt;
            r_mem_req    <= (w_pend_nxt != '0);
            r_chunk_addr <= w_addr_nxt;
            r_chunk_idx  <= w_idx_nxt;
            r_frame_done <= 1'b0;
            if (w_drop)
                r_err <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ACTIVE;
                        r_line_addr <= w_base;
                        r_stride    <= line_stride;
                        r_err       <= 1'b0;
                        r_go_pend   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (read_done)
                        r_state <= S_FRAME_DRAIN;
                    else if (read_next_line)
                        r_state <= S_LINE_DRAIN;
                end
                S_LINE_DRAIN: begin
                    if (read_done) begin
                        r_state <= S_FRAME_DRAIN;
                    end else begin
                        if (read_next_line)
                            r_err <= 1'b1;
                        if (w_drained) begin
                            r_line_addr <= r_line_addr + r_stride;
                            r_state     <= S_ACTIVE;
                        end
                    end
                end
                S_FRAME_DRAIN: begin
                    if (read_go)
                        r_go_pend <= 1'b1;
                    if (w_drained) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_chunk_addr;
    assign mem.mem_len  = LEN_W'(CHUNK_BYTES / 4);
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = r_frame_done;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_hdmi_read_ctrl.sv
// Testbench for hdmi_read_ctrl: vector table, directed corner cases,
// then random strobes against a queue-based reference model.
module tb_hdmi_read_ctrl;

    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int CB  = 128;
    localparam int CPL = 40;
    localparam int MP  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] fb_base = '0;
    logic [AW-1:0] line_stride = '0;
    logic          read_go = 1'b0;
    logic          read_next_line = 1'b0;
    logic          read_next_chunk = 1'b0;
    logic          read_done = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          err_overflow;
`ifdef DOUBLE_BUFFER_EN
    logic [AW-1:0] fb_base_alt = '0;
    logic          fb_swap = 1'b0;
    logic          fb_front;
`endif

    hdmi_read_ctrl_if #(.ADDR_W(AW), .LEN_W(LW)) mif ();

    hdmi_read_ctrl #(
        .ADDR_W(AW), .CHUNK_BYTES(CB), .CHUNKS_PER_LINE(CPL),
        .MAX_PENDING(MP), .LEN_W(LW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fb_base(fb_base),
        .line_stride(line_stride),
        .read_go(read_go),
        .read_next_line(read_next_line),
        .read_next_chunk(read_next_chunk),
        .read_done(read_done),
`ifdef DOUBLE_BUFFER_EN
        .fb_base_alt(fb_base_alt),
        .fb_swap(fb_swap),
        .fb_front(fb_front),
`endif
        .mem(mif.master),
        .busy(busy),
        .frame_done(frame_done),
        .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          go, ch, ln, dn, ak;
        bit          req;
        logic [31:0] addr;
        bit          bsy, err, fd;
    } vec_t;

    vec_t tv[$];

    // reference model state
    bit          m_frame, m_dpend, m_lpend, m_gopend, m_err, m_fd;
    logic [31:0] m_line, m_stride;
    int          m_nreq;
    logic [31:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit go, input bit ch, input bit ln, input bit dn, input bit ak);
        read_go = go;
        read_next_chunk = ch;
        read_next_line = ln;
        read_done = dn;
        mif.mem_ack = ak;
        @(posedge clock);
        #1;
        read_go = 1'b0;
        read_next_chunk = 1'b0;
        read_next_line = 1'b0;
        read_done = 1'b0;
        mif.mem_ack = 1'b0;
    endtask

    function automatic vec_t mk(bit go, bit ch, bit ln, bit dn, bit ak,
                                bit req, logic [31:0] addr, bit bsy, bit err, bit fd);
        vec_t v;
        v.go = go; v.ch = ch; v.ln = ln; v.dn = dn; v.ak = ak;
        v.req = req; v.addr = addr; v.bsy = bsy; v.err = err; v.fd = fd;
        return v;
    endfunction

    task automatic m_reset();
        m_frame = 0; m_dpend = 0; m_lpend = 0; m_gopend = 0;
        m_err = 0; m_fd = 0; m_line = '0; m_stride = '0; m_nreq = 0;
        m_q.delete();
    endtask

    // Spec rules per cycle: chunk queue of expected burst addresses
    task automatic m_update(input bit go, input bit ch, input bit ln, input bit dn, input bit ak);
        int psz;
        bit pempty, plp;
        psz = m_q.size();
        pempty = (psz == 0);
        plp = m_lpend;
        m_fd = 0;
        if (!m_frame) begin
            if (go || m_gopend) begin
                m_frame = 1; m_line = fb_base; m_stride = line_stride;
                m_nreq = 0; m_q.delete(); m_err = 0;
                m_lpend = 0; m_dpend = 0; m_gopend = 0;
            end
        end else begin
            if (ak && !pempty) void'(m_q.pop_front());
            if (m_dpend) begin
                if (go) m_gopend = 1;
                if (pempty) begin
                    m_frame = 0; m_dpend = 0; m_fd = 1;
                end
            end else begin
                if (ch) begin
                    if (psz == MP || m_nreq == CPL) m_err = 1;
                    else begin
                        m_q.push_back(m_line + 32'(m_nreq * CB));
                        m_nreq++;
                    end
                end
                if (dn) begin
                    m_dpend = 1; m_lpend = 0;
                end else begin
                    if (ln) begin
                        if (plp) m_err = 1;
                        else m_lpend = 1;
                    end
                    if (plp && pempty) begin
                        m_line = m_line + m_stride; m_nreq = 0; m_lpend = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        bit seen;
        int bursts;
        int fdcnt;
        mif.mem_ack = 1'b0;

        // reset values
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_req", mif.mem_req, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_err", err_overflow, 0);
        chk("mem_len", mif.mem_len, 32);
        reset = 1'b0;

        // vector table: three chunks, frame end/restart, line advance
        fb_base = 32'h1000;
        line_stride = 32'h1400;
        tv.push_back(mk(1,0,0,0,0, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 1,32'h1080, 1,0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h1080, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 1,32'h1100, 1,0,0));
        tv.push_back(mk(0,0,0,0,0, 1,32'h1100, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,0,0,1,0, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,32'h0,    0,0,1));
        tv.push_back(mk(1,0,0,0,0, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,0,1,0,0, 1,32'h1000, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 1,32'h1080, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,0,0,0,0, 0,32'h0,    1,0,0));
        tv.push_back(mk(0,1,0,0,0, 1,32'h2400, 1,0,0));
        tv.push_back(mk(0,0,0,0,1, 0,32'h0,    1,0,0));
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].go, tv[i].ch, tv[i].ln, tv[i].dn, tv[i].ak);
            chk($sformatf("tv%0d_req", i), mif.mem_req, tv[i].req);
            if (tv[i].req) chk($sformatf("tv%0d_addr", i), mif.mem_addr, tv[i].addr);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
            chk($sformatf("tv%0d_err", i), err_overflow, tv[i].err);
            chk($sformatf("tv%0d_fd", i), frame_done, tv[i].fd);
        end

        // overflow: five chunks with no ack, only four accepted
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            chk($sformatf("ovf_err%0d", i), err_overflow, (i == 4));
        end
        bursts = 0;
        for (int k = 0; k < 12 && mif.mem_req; k++) begin
            chk("ovf_addr", mif.mem_addr, 32'h2480 + 32'(bursts * CB));
            bursts++;
            step(0, 0, 0, 0, 1);
        end
        chk("ovf_bursts", bursts, 4);
        step(0, 0, 0, 1, 0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(0, 0, 0, 0, 0);
            seen = frame_done;
        end
        chk("ovf_fd_seen", seen, 1);
        chk("ovf_err_sticky", err_overflow, 1);
        step(1, 0, 0, 0, 0);
        chk("ovf_err_clr", err_overflow, 0);

        // frame drain with one chunk outstanding
        step(0, 1, 0, 0, 0);
        chk("fd_req", mif.mem_req, 1);
        step(0, 0, 0, 1, 0);
        chk("fd_busy_drain", busy, 1);
        step(0, 0, 0, 0, 0);
        chk("fd_req_hold", mif.mem_req, 1);
        chk("fd_addr_hold", mif.mem_addr, 32'h1000);
        fdcnt = 0;
        step(0, 0, 0, 0, 1);
        fdcnt += int'(frame_done);
        chk("fd_req_drop", mif.mem_req, 0);
        step(0, 0, 0, 0, 0);
        fdcnt += int'(frame_done);
        chk("fd_busy_low", busy, 0);
        step(0, 0, 0, 0, 0);
        fdcnt += int'(frame_done);
        chk("fd_busy_after", busy, 0);
        chk("fd_once", fdcnt, 1);

        // read_go held during frame drain
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        fb_base = 32'h5000;
        step(1, 0, 0, 0, 0);
        chk("gp_busy", busy, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("gp_fd", frame_done, 1);
        chk("gp_idle", busy, 0);
        step(0, 0, 0, 0, 0);
        chk("gp_fd_end", frame_done, 0);
        chk("gp_restart", busy, 1);
        step(0, 1, 0, 0, 0);
        chk("gp_addr", mif.mem_addr, 32'h5000);

        // chunk coincident with ack keeps pending
        step(0, 1, 0, 0, 1);
        chk("co_req", mif.mem_req, 1);
        chk("co_addr", mif.mem_addr, 32'h5080);
        step(0, 0, 0, 0, 1);
        chk("co_req_end", mif.mem_req, 0);
        step(0, 1, 0, 0, 0);
        chk("rs_req_pre", mif.mem_req, 1);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("rs_req", mif.mem_req, 0);
        chk("rs_busy", busy, 0);
        chk("rs_addr", mif.mem_addr, 0);
        reset = 1'b0;

`ifdef DOUBLE_BUFFER_EN
        fb_base = 32'h1000;
        fb_base_alt = 32'h80000;
        step(1, 0, 0, 0, 0);
        chk("db_front0", fb_front, 0);
        step(0, 1, 0, 0, 0);
        chk("db_addr0", mif.mem_addr, 32'h1000);
        fb_swap = 1'b1;
        step(0, 0, 0, 0, 0);
        fb_swap = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("db_addr_mid", mif.mem_addr, 32'h1080);
        chk("db_front_mid", fb_front, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("db_fd", frame_done, 1);
        step(1, 0, 0, 0, 0);
        chk("db_front1", fb_front, 1);
        step(0, 1, 0, 0, 0);
        chk("db_addr_alt", mif.mem_addr, 32'h80000);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
`endif

        // random strobes against the reference model
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        m_reset();
        fb_base = $urandom;
        line_stride = $urandom;
        for (int c = 0; c < 3000; c++) begin
            bit go, ch, ln, dn, ak;
            bit exp_req;
            if ($urandom_range(0, 19) == 0) fb_base = $urandom;
            if ($urandom_range(0, 19) == 0) line_stride = $urandom;
            go = m_frame ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 3) == 0);
            ch = !m_lpend && ($urandom_range(0, 99) < 35);
            ln = ($urandom_range(0, 99) < 4);
            dn = ($urandom_range(0, 199) < 3);
            ak = 1'($urandom_range(0, 1));
            m_update(go, ch, ln, dn, ak);
            step(go, ch, ln, dn, ak);
            exp_req = m_frame && (m_q.size() > 0);
            chk("rnd_busy", busy, m_frame);
            chk("rnd_req", mif.mem_req, exp_req);
            if (exp_req) chk("rnd_addr", mif.mem_addr, m_q[0]);
            chk("rnd_fd", frame_done, m_fd);
            chk("rnd_err", err_overflow, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
